// File: rtl/sram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sram_rr_arbiter
// Round-robin arbiter that shares one single-port SRAM among NumReq requesters.
// One request is granted per cycle. Read responses come back Latency cycles
// after the grant and are routed to the requester that issued them.
//
// Optional feature (compile-time macro SRAM_ARB_ADDR_CHECK_EN):
//   Requests with addr >= NumWords are accepted but are not forwarded to the
//   SRAM. Reads return rsp_err_o = 1 with zero data. Writes are dropped.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i/ready_o  per-requester handshake (ready is one-hot or zero)
//   req_we/addr/wdata/be per-requester request fields
//   rsp_valid_o          per-requester one-cycle read response pulse
//   rsp_rdata_o/err_o    shared response data / error, qualified by rsp_valid_o
//   mem_*                SRAM request port; mem_rdata_i valid Latency cycles
//                        after a read request
// ----------------------------------------------------------------------------
module sram_rr_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned IdxWidth  = $clog2(NumReq)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  logic [NumReq-1:0]                  req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]     req_be_i,
    output logic [NumReq-1:0]                  rsp_valid_o,
    output logic [DataWidth-1:0]               rsp_rdata_o,
    output logic                               rsp_err_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [AddrWidth-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]               mem_wdata_o,
    output logic [BeWidth-1:0]                 mem_be_o,
    input  logic [DataWidth-1:0]               mem_rdata_i
);

    // (a + b) mod NumReq, for pointer-relative requester indices
    function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] a,
                                                     input int unsigned         b);
        return IdxWidth'((32'(a) + b) % NumReq);
    endfunction

    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] gnt_idx;
    logic                gnt_found;
    logic                hs;
    logic                addr_bad;

    // Response pipeline: one {valid, index, err} entry per latency stage
    logic [Latency-1:0]  pipe_vld_q;
    logic [Latency-1:0]  pipe_err_q;
    logic [IdxWidth-1:0] pipe_idx_q [Latency];

    logic                rsp_vld;
    logic                rsp_err;

    // Round-robin pick: first valid index at or above the pointer, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!gnt_found && req_valid_i[wrap_add(ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    // Grants are suppressed while reset is asserted
    assign hs = gnt_found && rst_ni;

    always_comb begin
        req_ready_o = '0;
        if (hs) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

`ifdef SRAM_ARB_ADDR_CHECK_EN
    assign addr_bad = hs && (32'(req_addr_i[gnt_idx]) >= NumWords);
`else
    assign addr_bad = 1'b0;
`endif

    // SRAM request fields follow the granted requester
    assign mem_req_o   = hs && !addr_bad;
    assign mem_we_o    = req_we_i[gnt_idx];
    assign mem_addr_o  = req_addr_i[gnt_idx];
    assign mem_wdata_o = req_wdata_i[gnt_idx];
    assign mem_be_o    = req_be_i[gnt_idx];

    assign ptr_d = hs ? wrap_add(gnt_idx, 32'd1) : ptr_q;

    // Pointer and response pipeline registers; reset drops in-flight reads
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            for (int unsigned i = 0; i < Latency; i++) begin
                pipe_idx_q[i] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            pipe_vld_q[0] <= hs && !req_we_i[gnt_idx];
            pipe_err_q[0] <= addr_bad;
            pipe_idx_q[0] <= gnt_idx;
            for (int unsigned i = 1; i < Latency; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    assign rsp_vld = pipe_vld_q[Latency-1];
    assign rsp_err = pipe_err_q[Latency-1];

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_vld) begin
            rsp_valid_o[pipe_idx_q[Latency-1]] = 1'b1;
        end
    end

    // Data is zeroed when idle and for error responses
    assign rsp_rdata_o = (rsp_vld && !rsp_err) ? mem_rdata_i : '0;

`ifdef SRAM_ARB_ADDR_CHECK_EN
    assign rsp_err_o = rsp_vld && rsp_err;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_rr_arbiter
// Self-checking bench for sram_rr_arbiter (NumReq=4, DataWidth=32, Latency=2).
// A behavioural SRAM sits on the mem_* port; a reference model predicts grants
// and the responses from a separate reference memory.
// ----------------------------------------------------------------------------
module tb_sram_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int AW  = 10;
    localparam int LAT = 2;
`ifdef SRAM_ARB_ADDR_CHECK_EN
    localparam int NW         = 1000;
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam int NW         = 1024;
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            req_we;
    logic [N-1:0][AW-1:0]    req_addr;
    logic [N-1:0][DW-1:0]    req_wdata;
    logic [N-1:0][BW-1:0]    req_be;
    logic [N-1:0]            rsp_valid;
    logic [DW-1:0]           rsp_rdata;
    logic                    rsp_err;
    logic                    mem_req;
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic [BW-1:0]           mem_be;
    logic [DW-1:0]           mem_rdata;

    sram_rr_arbiter #(
        .NumReq   (N),
        .NumWords (NW),
        .DataWidth(DW),
        .ByteWidth(8),
        .Latency  (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_be_i   (req_be),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o   (mem_be),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural SRAM on the mem_* port ----------------
    logic          fill;
    logic [DW-1:0] sram [1024];
    logic [DW-1:0] rdp  [LAT];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) sram[i] <= 32'(i) * 32'h9E3779B9;
        end else if (mem_req && mem_we) begin
            for (int b = 0; b < BW; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_req && !mem_we) rdp[0] <= sram[mem_addr];
        for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign mem_rdata = rdp[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          idx;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] ref_mem [1024];
    int          m_ptr;
    int          cyc;
    int          n_checks;
    int          n_errors;

    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [31:0]  exp_rdata;
    logic         exp_err;
    bit           exp_hs;
    bit           exp_bad;
    bit           exp_mreq;
    int           exp_idx;

    // Expected outputs for the current cycle, from the current inputs
    task automatic predict();
        exp_rdy = '0; exp_hs = 1'b0; exp_idx = 0;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (!exp_hs && req_valid[k]) begin
                    exp_hs = 1'b1; exp_idx = k; exp_rdy[k] = 1'b1;
                end
            end
        end
        exp_bad  = ADDR_CHECK && exp_hs && (int'(req_addr[exp_idx]) >= NW);
        exp_mreq = exp_hs && !exp_bad;
        exp_rv = '0; exp_rdata = '0; exp_err = 1'b0;
        foreach (pend[j]) begin
            if (pend[j].due == cyc) begin
                exp_rv[pend[j].idx] = 1'b1;
                exp_rdata = pend[j].data;
                exp_err   = pend[j].err;
            end
        end
    endtask

    // Advance one clock and apply the predicted transaction to the model
    task automatic commit();
        rsp_t r;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0;
            pend.delete();
        end else if (exp_hs) begin
            m_ptr = (exp_idx + 1) % N;
            if (!req_we[exp_idx]) begin
                r.due  = cyc + LAT;
                r.idx  = exp_idx;
                r.err  = exp_bad;
                r.data = exp_bad ? 32'h0 : ref_mem[req_addr[exp_idx]];
                pend.push_back(r);
            end else if (!exp_bad) begin
                for (int b = 0; b < BW; b++)
                    if (req_be[exp_idx][b])
                        ref_mem[req_addr[exp_idx]][8*b +: 8] = req_wdata[exp_idx][8*b +: 8];
            end
        end
        for (int j = pend.size() - 1; j >= 0; j--)
            if (pend[j].due <= cyc) pend.delete(j);
        cyc++;
        #1;
    endtask

    task automatic set_req(int k, bit v, bit we, int addr, logic [31:0] wd, logic [3:0] be);
        req_valid[k] = v;
        req_we[k]    = we;
        req_addr[k]  = AW'(addr);
        req_wdata[k] = wd;
        req_be[k]    = be;
    endtask

    task automatic new_req(int k);
        int a;
        if (ADDR_CHECK && $urandom_range(0, 7) == 0) a = $urandom_range(NW, 1023);
        else                                          a = $urandom_range(0, 15);
        set_req(k, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a,
                $urandom, 4'($urandom_range(0, 15)));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, k, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== 4'b0000 || mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_grant cyc=%0d ready=%b mem_req=%b expected ready=0000 mem_req=0",
                         cyc, req_ready, mem_req);
            end
            n_checks++;
            if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_rsp cyc=%0d valid=%b rdata=%h err=%b expected 0000/0/0",
                         cyc, rsp_valid, rsp_rdata, rsp_err);
            end
            commit();
            fill = 1'b0;
        end
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_rr_read();
        logic [N-1:0] want;
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            for (int k = 0; k < N; k++) set_req(k, i < 8, 1'b0, 8 + k, 32'h0, 4'hF);
            @(negedge clk); predict();
            want = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
            n_checks++;
            if (req_ready !== want || mem_req !== (i < 8)) begin
                n_errors++;
                $display("FAIL rr_order i=%0d ready=%b mem_req=%b expected ready=%b", i, req_ready, mem_req, want);
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL rr_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 5; i++) begin
            req_valid = '0;
            if (i == 0) set_req(2, 1'b1, 1'b1, 5, 32'hDEADBEEF, 4'hF);
            if (i == 1) set_req(0, 1'b1, 1'b0, 5, 32'h0, 4'hF);
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== exp_rdy || mem_req !== exp_mreq) begin
                n_errors++;
                $display("FAIL wr_grant i=%0d ready=%b mem_req=%b expected %b/%b", i, req_ready, mem_req, exp_rdy, exp_mreq);
            end
            if (i == 0) begin
                n_checks++;
                if (mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin
                    n_errors++;
                    $display("FAIL wr_fields we=%b addr=%0d wdata=%h be=%h expected 1/5/deadbeef/f",
                             mem_we, mem_addr, mem_wdata, mem_be);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEADBEEF) begin
                    n_errors++;
                    $display("FAIL rd_after_wr valid=%b rdata=%h expected 0001/deadbeef", rsp_valid, rsp_rdata);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL wr_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 9; i++) begin
            req_valid = '0;
            if (i < 6) set_req(3, 1'b1, 1'b0, 20 + i, 32'h0, 4'hF);
            if (i == 5) set_req(0, 1'b1, 1'b0, 30, 32'h0, 4'hF);
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== ((i < 5) ? 4'b1000 : (i == 5) ? 4'b0001 : 4'b0000)) begin
                n_errors++;
                $display("FAIL single_grant i=%0d ready=%b", i, req_ready);
            end
            if (i >= 2 && i <= 6) begin
                n_checks++;
                if (rsp_valid !== 4'b1000) begin
                    n_errors++;
                    $display("FAIL single_rsp i=%0d valid=%b expected 1000", i, rsp_valid);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL single_data i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
    endtask

    task automatic test_ptr_wrap();
        for (int i = 0; i < 6; i++) begin
            req_valid = '0;
            if (i < 3)  set_req(1, 1'b1, 1'b0, 40, 32'h0, 4'hF);
            if (i == 1) set_req(3, 1'b1, 1'b0, 43, 32'h0, 4'hF);
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== ((i == 1) ? 4'b1000 : (i < 3) ? 4'b0010 : 4'b0000)) begin
                n_errors++;
                $display("FAIL ptr_grant i=%0d ready=%b", i, req_ready);
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL ptr_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
    endtask

    task automatic test_reset_inflight();
        logic [N-1:0] want;
        for (int i = 0; i < 7; i++) begin
            req_valid = '0;
            rst_n = (i != 1);
            if (i < 3)  set_req(0, 1'b1, 1'b0, 50, 32'h0, 4'hF);
            if (i < 4)  set_req(1, 1'b1, 1'b0, 51, 32'h0, 4'hF);
            @(negedge clk); predict();
            case (i)
                0, 2:    want = 4'b0001;
                3:       want = 4'b0010;
                default: want = 4'b0000;
            endcase
            n_checks++;
            if (req_ready !== want) begin
                n_errors++;
                $display("FAIL rst_inflight_grant i=%0d ready=%b expected %b", i, req_ready, want);
            end
            if (i == 2 || i == 3) begin
                n_checks++;
                if (rsp_valid !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL rst_dropped i=%0d valid=%b expected 0000", i, rsp_valid);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL rst_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
        rst_n = 1'b1;
    endtask

`ifdef SRAM_ARB_ADDR_CHECK_EN
    task automatic test_addr_check();
        for (int i = 0; i < 5; i++) begin
            req_valid = '0;
            if (i == 0) set_req(2, 1'b1, 1'b0, 1020, 32'h0, 4'hF);
            if (i == 1) set_req(1, 1'b1, 1'b1, 1010, 32'h12345678, 4'hF);
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== exp_rdy || mem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL addr_grant i=%0d ready=%b mem_req=%b expected %b/0", i, req_ready, mem_req, exp_rdy);
            end
            if (i == 2) begin
                n_checks++;
                if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
                    n_errors++;
                    $display("FAIL addr_err valid=%b err=%b rdata=%h expected 0100/1/0", rsp_valid, rsp_err, rsp_rdata);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL addr_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < N; k++) new_req(k);
        for (int i = 0; i < 400; i++) begin
            if (i >= 390) req_valid = '0;
            @(negedge clk); predict();
            n_checks++;
            if (req_ready !== exp_rdy || mem_req !== exp_mreq) begin
                n_errors++;
                $display("FAIL rand_grant i=%0d ready=%b mem_req=%b expected %b/%b", i, req_ready, mem_req, exp_rdy, exp_mreq);
            end
            if (exp_mreq) begin
                n_checks++;
                if (mem_we !== req_we[exp_idx] || mem_addr !== req_addr[exp_idx] ||
                    (req_we[exp_idx] && (mem_wdata !== req_wdata[exp_idx] || mem_be !== req_be[exp_idx]))) begin
                    n_errors++;
                    $display("FAIL rand_fields i=%0d we=%b addr=%0d wdata=%h be=%h expected req %0d",
                             i, mem_we, mem_addr, mem_wdata, mem_be, exp_idx);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rv || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
                n_errors++;
                $display("FAIL rand_rsp i=%0d valid=%b rdata=%h err=%b expected %b/%h/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rdata, exp_err);
            end
            commit();
            if (i < 390) begin
                if (exp_hs) new_req(exp_idx);
                for (int k = 0; k < N; k++)
                    if (!req_valid[k] && $urandom_range(0, 2) == 0) new_req(k);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_ptr    = 0;
        fill     = 1'b1;
        rst_n    = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i) * 32'h9E3779B9;

        test_reset();
        test_rr_read();
        test_write_read();
        test_single();
        test_ptr_wrap();
        test_reset_inflight();
`ifdef SRAM_ARB_ADDR_CHECK_EN
        test_addr_check();
`endif
        test_random();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters; range 2..16.
REQ-002 SHALL have parameter NumWords, default 1024: words in the shared SRAM.
REQ-003 SHALL have parameter DataWidth, default 32: data width.
REQ-004 SHALL have parameter ByteWidth, default 8: byte width; BeWidth = ceil(DataWidth/ByteWidth).
REQ-005 SHALL have parameter Latency, default 1: SRAM read latency in cycles; range 1..4.
REQ-006 SHALL derive AddrWidth = (NumWords > 1) ? clog2(NumWords) : 1, and IdxWidth = clog2(NumReq).
REQ-007 clk_i  input  1  single clock; all logic on rising edge.
REQ-008 rst_ni  input  1  reset, synchronous, active-low.
REQ-009 req_valid_i  input  NumReq  per-requester request valid.
REQ-010 req_ready_o  output  NumReq  per-requester grant; handshake on valid&ready.
REQ-011 req_we_i  input  NumReq  per-requester write enable.
REQ-012 req_addr_i  input  NumReq x AddrWidth  per-requester word address.
REQ-013 req_wdata_i  input  NumReq x DataWidth  per-requester write data.
REQ-014 req_be_i  input  NumReq x BeWidth  per-requester byte enable.
REQ-015 rsp_valid_o  output  NumReq  per-requester read response valid, one cycle pulse.
REQ-016 rsp_rdata_o  output  DataWidth  read data, shared by all requesters, qualified by rsp_valid_o.
REQ-017 rsp_err_o  output  1  response error flag, qualified by rsp_valid_o.
REQ-018 mem_req_o / mem_we_o  output  1 each  SRAM request and write enable.
REQ-019 mem_addr_o / mem_wdata_o / mem_be_o  output  AddrWidth / DataWidth / BeWidth  SRAM request fields.
REQ-020 mem_rdata_i  input  DataWidth  SRAM read data, valid Latency cycles after a read request.

Function
REQ-021 SHALL grant at most one requester per cycle; req_ready_o SHALL be one-hot or zero, combinationally derived from req_valid_i and the priority pointer.
REQ-022 Arbitration SHALL be round-robin: the first valid index at or above the pointer wins, wrapping from NumReq-1 to 0.
REQ-023 After a handshake on index k, the pointer SHALL become (k+1) mod NumReq; without a handshake the pointer SHALL hold.
REQ-024 On a handshake, mem_req_o SHALL be 1 in the same cycle, and mem_we/addr/wdata/be SHALL equal the granted requester's fields; otherwise mem_req_o SHALL be 0.
REQ-025 Throughput SHALL be one request per cycle; a single requester holding valid SHALL be granted every cycle.
REQ-026 For each granted read, rsp_valid_o[k] SHALL pulse exactly Latency cycles after the handshake, with rsp_rdata_o = mem_rdata_i in that cycle.
REQ-027 Writes SHALL produce no response.
REQ-028 Response routing SHALL use a Latency-deep shift register of {valid, index, err}, advancing every cycle; there is no response backpressure.
REQ-029 When rsp_valid_o is all zero, rsp_rdata_o SHALL be 0 and rsp_err_o SHALL be 0.
REQ-030 A requester that is not granted SHALL hold its request; the arbiter SHALL not buffer requests.

Reset
REQ-031 While rst_ni = 0 at a clock edge, the pointer SHALL become 0 and the response pipeline SHALL be cleared.
REQ-032 req_ready_o and mem_req_o SHALL be forced to 0 while rst_ni = 0.
REQ-033 Reads in flight at reset SHALL be dropped; no rsp_valid_o SHALL occur for them after reset is released.

Configuration
REQ-034 With SRAM_ARB_ADDR_CHECK_EN defined, a granted request with addr >= NumWords SHALL assert req_ready_o, keep mem_req_o = 0, and advance the pointer.
REQ-035 With SRAM_ARB_ADDR_CHECK_EN defined, such a request that is a read SHALL return rsp_valid_o after Latency cycles with rsp_err_o = 1 and rsp_rdata_o = 0; such a write SHALL be silently dropped.
REQ-036 Without SRAM_ARB_ADDR_CHECK_EN, all addresses SHALL be forwarded unchanged and rsp_err_o SHALL be tied to 0.

Verification
REQ-037 Reset, then all 4 requesters reading for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_valid_o[k] arrives Latency cycles after its grant.
REQ-038 Latency=2, requester 2 writes 0xDEADBEEF with be=0xF to addr 5, then requester 0 reads addr 5 -> rsp_valid_o[0] pulses 2 cycles after the read grant with rdata 0xDEADBEEF; no response for the write.
REQ-039 Only requester 3 valid for 5 cycles -> granted every cycle, pointer ends at 0, 5 consecutive responses on index 3.
REQ-040 Requesters 1 and 3 valid with pointer=2 -> 3 is granted first, then 1.
REQ-041 Reads issued to requesters 0 and 1, then rst_ni = 0 for one cycle before the responses are due -> no rsp_valid_o, pointer = 0.
REQ-042 With SRAM_ARB_ADDR_CHECK_EN, NumWords=1000, a read to addr 1020 -> mem_req_o = 0, and after Latency cycles rsp_err_o = 1 with rsp_rdata_o = 0.
